apb_slave: RTL

- APB slave front-end; the responder end of the APB link.
- Accepts APB3/APB4 transfers on its APB port and re-issues each one as a command on a simple valid-ready interface, using the command/response packing the team's APB master uses.
- Waits for the matching response, then completes the APB access phase with PREADY, PRDATA and PSLVERR.
- Sits in front of register banks and memory-mapped peripherals that expose a valid-ready command/response port.

---
 rtl/apb_slave_if.sv | 38 +++
 rtl/apb_slave.sv | 131 +++++++++++++
 2 files changed

// File: rtl/apb_slave_if.sv
// APB slave port bundle: APB bus side plus the downstream valid-ready command/response link.
// Signal names match the block's pin list; the slave modport is the DUT view.
interface apb_slave_if #(
  parameter int DW = 32,
  parameter int AW = 8
);
  localparam int SW = DW / 8;
  localparam int CW = 1 + SW + DW + AW;
  localparam int RW = 1 + DW;

  logic [AW-1:0] i_paddr;
  logic          i_pwrite;
  logic          i_psel;
  logic          i_penable;
  logic [DW-1:0] i_pwdata;
  logic [SW-1:0] i_pstrb;
  logic [DW-1:0] o_prdata;
  logic          o_pslverr;
  logic          o_pready;
  logic [CW-1:0] o_cmd;
  logic          o_cmd_valid;
  logic          i_cmd_ready;
  logic [RW-1:0] i_resp;
  logic          i_resp_valid;
  logic          o_resp_ready;

  modport slave (
    input  i_paddr, i_pwrite, i_psel, i_penable, i_pwdata, i_pstrb,
    input  i_cmd_ready, i_resp, i_resp_valid,
    output o_prdata, o_pslverr, o_pready, o_cmd, o_cmd_valid, o_resp_ready
  );

  modport master (
    output i_paddr, i_pwrite, i_psel, i_penable, i_pwdata, i_pstrb,
    output i_cmd_ready, i_resp, i_resp_valid,
    input  o_prdata, o_pslverr, o_pready, o_cmd, o_cmd_valid, o_resp_ready
  );
endinterface

// File: rtl/apb_slave.sv
// APB3/APB4 slave front-end: turns each APB transfer into a valid-ready command and waits for its response.
// Optional macro APB_SLAVE_TIMEOUT_EN: abort with PSLVERR after TMO cycles and sink late responses in IDLE.
module apb_slave #(
  parameter int DW  = 32,
  parameter int AW  = 8,
  parameter int TMO = 16
) (
  input  logic       pclk,
  input  logic       preset,
  apb_slave_if.slave bus
);
  localparam int SW = DW / 8;
  localparam int CW = 1 + SW + DW + AW;

  if (TMO < 2 || AW > 32 || (DW % 8) != 0) begin : g_param_chk
    $error("apb_slave: illegal parameter set");
  end

  typedef enum logic [1:0] {IDLE, CMD, RESP, DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cmd_q, cmd_d;
  logic [DW-1:0] prdata_q, prdata_d;
  logic          pslverr_q, pslverr_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic          resp_ready_q, resp_ready_d;
  logic          pready_q, pready_d;
  logic          setup;
  logic          tmo_hit;
  logic          sink_idle;

  assign setup = bus.i_psel && !bus.i_penable;

`ifdef APB_SLAVE_TIMEOUT_EN
  localparam int TCW = $clog2(TMO);
  logic [TCW-1:0] cnt_q, cnt_d;

  assign tmo_hit   = (cnt_q == TCW'(TMO - 1));
  assign sink_idle = 1'b1;

  always_comb begin
    cnt_d = cnt_q;
    case (state_q)
      IDLE:      if (setup) cnt_d = '0;
      CMD, RESP: cnt_d = cnt_q + 1'b1;
      default:   cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign tmo_hit   = 1'b0;
  assign sink_idle = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    prdata_d  = prdata_q;
    pslverr_d = pslverr_q;
    case (state_q)
      IDLE: begin
        // Reads carry a zero strobe so the downstream never sees stray byte enables.
        if (setup) begin
          cmd_d   = {bus.i_pwrite, bus.i_pstrb & {SW{bus.i_pwrite}}, bus.i_pwdata, bus.i_paddr};
          state_d = CMD;
        end
      end
      CMD: begin
        if (bus.i_cmd_ready) begin
          state_d = RESP;
        end else if (tmo_hit) begin
          state_d   = DONE;
          pslverr_d = 1'b1;
          prdata_d  = '0;
        end
      end
      RESP: begin
        if (bus.i_resp_valid) begin
          state_d   = DONE;
          pslverr_d = bus.i_resp[DW];
          prdata_d  = cmd_q[CW-1] ? '0 : bus.i_resp[DW-1:0];
        end else if (tmo_hit) begin
          state_d   = DONE;
          pslverr_d = 1'b1;
          prdata_d  = '0;
        end
      end
      DONE: begin
        state_d   = IDLE;
        prdata_d  = '0;
        pslverr_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    // Handshake outputs are registered from the next state, so they track the FSM with no input paths.
    cmd_valid_d  = (state_d == CMD);
    resp_ready_d = (state_d == RESP) || (sink_idle && state_d == IDLE);
    pready_d     = (state_d == DONE);
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q      <= IDLE;
      cmd_q        <= '0;
      prdata_q     <= '0;
      pslverr_q    <= 1'b0;
      cmd_valid_q  <= 1'b0;
      resp_ready_q <= 1'b0;
      pready_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      prdata_q     <= prdata_d;
      pslverr_q    <= pslverr_d;
      cmd_valid_q  <= cmd_valid_d;
      resp_ready_q <= resp_ready_d;
      pready_q     <= pready_d;
    end
  end

  assign bus.o_cmd        = cmd_q;
  assign bus.o_cmd_valid  = cmd_valid_q;
  assign bus.o_resp_ready = resp_ready_q;
  assign bus.o_prdata     = prdata_q;
  assign bus.o_pslverr    = pslverr_q;
  assign bus.o_pready     = pready_q;
endmodule
